// File: rtl/regfile_access_arbiter.sv
// ============================================================================
// regfile_access_arbiter
//
// Purpose:
//   Arbiter and access sequencer for the single-port shared DMA register file.
//   Three requesters compete for it: the AXI slave write FSM, the AXI slave
//   read FSM and the DMA channel engine. Ownership is granted per burst:
//   - The AXI sides keep the regfile for their whole "occupied" window.
//   - The DMA engine is time-sliced by a beat quota whenever somebody else
//     is waiting.
//   The owner's access is steered onto the regfile port. Read data, which
//   returns one cycle after the access, is routed back to whichever
//   requester issued the read.
//
// Parameters:
//   REGFILE_ADDRWIDTH  regfile address width
//   REGFILE_DATAWIDTH  regfile data width
//   DMA_MAX_BEATS      DMA accesses per grant while another requester waits (>=1)
//   BEAT_CNT_W         width of the DMA beat counter
//
// Ports:
//   AXI_aclk, AXI_areset          clock, synchronous active-high reset
//   wr_occupied / sys_write*      slave write FSM request, strobe, address, data
//   sys_writeReady                write side owns the regfile
//   rd_occupied / sys_read*       slave read FSM request, strobe, address
//   sys_readReady                 read side owns the regfile
//   sys_readData / sys_readValid  read return to the slave read FSM
//   dma_req / dma_en / dma_we     DMA request, access strobe, write select
//   dma_addr / dma_wdata          DMA address and write data
//   dma_ready                     DMA owns the regfile
//   dma_rdata / dma_rvalid        read return to the DMA engine
//   rf_en/rf_we/rf_addr/rf_wdata  regfile access port
//   rf_rdata                      regfile read data (one cycle after the read)
// ============================================================================
module regfile_access_arbiter #(
    parameter int REGFILE_ADDRWIDTH = 9,
    parameter int REGFILE_DATAWIDTH = 9,
    parameter int DMA_MAX_BEATS     = 4,
    parameter int BEAT_CNT_W        = $clog2(DMA_MAX_BEATS + 1)
) (
    input  logic                         AXI_aclk,
    input  logic                         AXI_areset,

    input  logic                         wr_occupied,
    input  logic                         sys_writeEnable,
    input  logic [REGFILE_ADDRWIDTH-1:0] sys_writeAddress,
    input  logic [REGFILE_DATAWIDTH-1:0] sys_writeData,
    output logic                         sys_writeReady,

    input  logic                         rd_occupied,
    input  logic                         sys_readEnable,
    input  logic [REGFILE_ADDRWIDTH-1:0] sys_readAddress,
    output logic                         sys_readReady,
    output logic [REGFILE_DATAWIDTH-1:0] sys_readData,
    output logic                         sys_readValid,

    input  logic                         dma_req,
    input  logic                         dma_en,
    input  logic                         dma_we,
    input  logic [REGFILE_ADDRWIDTH-1:0] dma_addr,
    input  logic [REGFILE_DATAWIDTH-1:0] dma_wdata,
    output logic                         dma_ready,
    output logic [REGFILE_DATAWIDTH-1:0] dma_rdata,
    output logic                         dma_rvalid,

    output logic                         rf_en,
    output logic                         rf_we,
    output logic [REGFILE_ADDRWIDTH-1:0] rf_addr,
    output logic [REGFILE_DATAWIDTH-1:0] rf_wdata,
    input  logic [REGFILE_DATAWIDTH-1:0] rf_rdata
);

    typedef enum logic [1:0] {
        NONE    = 2'd0,
        GNT_WR  = 2'd1,
        GNT_RD  = 2'd2,
        GNT_DMA = 2'd3
    } state_t;

    localparam logic [BEAT_CNT_W-1:0] LAST_BEAT = BEAT_CNT_W'(DMA_MAX_BEATS - 1);
    localparam logic [BEAT_CNT_W-1:0] ONE_BEAT  = BEAT_CNT_W'(1);

    state_t                state;
    state_t                last_owner;
    logic [BEAT_CNT_W-1:0] beat_cnt;
    logic                  tag_sys_rd;
    logic                  tag_dma_rd;

    logic [2:0]            req_vec;
    logic [2:0]            owner_mask;
    state_t                pick_all;
    state_t                pick_other;
    logic                  dma_beat;
    logic                  quota_hit;
    logic                  others_pending;

    logic                         acc_en;
    logic                         acc_we;
    logic [REGFILE_ADDRWIDTH-1:0] acc_addr;
    logic [REGFILE_DATAWIDTH-1:0] acc_wdata;

    // Round-robin pick: search starts just after the last granted owner, so
    // with the pointer at its reset value (DMA) the order is WR, RD, DMA.
    // req bit 0 = write, bit 1 = read, bit 2 = DMA.
    function automatic state_t rr_pick(input logic [2:0] req, input state_t last);
        state_t win;
        win = NONE;
        case (last)
            GNT_WR: begin
                if (req[1])      win = GNT_RD;
                else if (req[2]) win = GNT_DMA;
                else if (req[0]) win = GNT_WR;
            end
            GNT_RD: begin
                if (req[2])      win = GNT_DMA;
                else if (req[0]) win = GNT_WR;
                else if (req[1]) win = GNT_RD;
            end
            default: begin
                if (req[0])      win = GNT_WR;
                else if (req[1]) win = GNT_RD;
                else if (req[2]) win = GNT_DMA;
            end
        endcase
        return win;
    endfunction

    // The releasing owner is masked out of the handover pick so a burst
    // never re-grants itself while it is letting go.
    always_comb begin
        req_vec    = {dma_req, rd_occupied, wr_occupied};
        owner_mask = 3'b000;
        case (state)
            GNT_WR:  owner_mask = 3'b001;
            GNT_RD:  owner_mask = 3'b010;
            GNT_DMA: owner_mask = 3'b100;
            default: owner_mask = 3'b000;
        endcase
        pick_all       = rr_pick(req_vec, last_owner);
        pick_other     = rr_pick(req_vec & ~owner_mask, last_owner);
        dma_beat       = dma_en && (state == GNT_DMA);
        quota_hit      = dma_beat && (beat_cnt == LAST_BEAT);
        others_pending = wr_occupied || rd_occupied;
    end

    // Grant FSM, round-robin pointer, DMA beat counter and read-return tags.
    // Every transition out of a grant goes straight to the next winner, so
    // there is never an idle cycle between owners while someone is waiting.
    always_ff @(posedge AXI_aclk) begin
        if (AXI_areset) begin
            state      <= NONE;
            last_owner <= GNT_DMA;
            beat_cnt   <= '0;
            tag_sys_rd <= 1'b0;
            tag_dma_rd <= 1'b0;
        end else begin
            // Tags follow the access itself, not the grant, so a read in the
            // last cycle of a grant still returns to its issuer after handover.
            tag_sys_rd <= acc_en && !acc_we && (state == GNT_RD);
            tag_dma_rd <= acc_en && !acc_we && (state == GNT_DMA);

            case (state)
                NONE: begin
                    if (pick_all != NONE) begin
                        state      <= pick_all;
                        last_owner <= pick_all;
                        beat_cnt   <= '0;
                    end
                end
                GNT_WR: begin
                    if (!wr_occupied) begin
                        state    <= pick_other;
                        beat_cnt <= '0;
                        if (pick_other != NONE) last_owner <= pick_other;
                    end
                end
                GNT_RD: begin
                    if (!rd_occupied) begin
                        state    <= pick_other;
                        beat_cnt <= '0;
                        if (pick_other != NONE) last_owner <= pick_other;
                    end
                end
                GNT_DMA: begin
                    if (!dma_req || (quota_hit && others_pending)) begin
                        state    <= pick_other;
                        beat_cnt <= '0;
                        if (pick_other != NONE) last_owner <= pick_other;
                    end else if (dma_beat) begin
                        // Quota reached with nobody waiting: start a fresh
                        // slice but keep the grant.
                        beat_cnt <= quota_hit ? '0 : beat_cnt + ONE_BEAT;
                    end
                end
                default: state <= NONE;
            endcase
        end
    end

    // Readies are pure decodes of the registered grant.
    assign sys_writeReady = (state == GNT_WR);
    assign sys_readReady  = (state == GNT_RD);
    assign dma_ready      = (state == GNT_DMA);

    // Owner access mux; strobes from anyone but the owner are dropped.
    always_comb begin
        acc_en    = 1'b0;
        acc_we    = 1'b0;
        acc_addr  = '0;
        acc_wdata = '0;
        case (state)
            GNT_WR: begin
                acc_en    = sys_writeEnable;
                acc_we    = 1'b1;
                acc_addr  = sys_writeAddress;
                acc_wdata = sys_writeData;
            end
            GNT_RD: begin
                acc_en    = sys_readEnable;
                acc_we    = 1'b0;
                acc_addr  = sys_readAddress;
            end
            GNT_DMA: begin
                acc_en    = dma_en;
                acc_we    = dma_we;
                acc_addr  = dma_addr;
                acc_wdata = dma_wdata;
            end
            default: begin
                acc_en    = 1'b0;
                acc_we    = 1'b0;
                acc_addr  = '0;
                acc_wdata = '0;
            end
        endcase
    end

    // No regfile access and no read return while reset is held, so a burst
    // cut short by reset cannot write the regfile or leak a stale rvalid.
    assign rf_en    = acc_en && !AXI_areset;
    assign rf_we    = acc_we && rf_en;
    assign rf_addr  = acc_addr;
    assign rf_wdata = acc_wdata;

    assign sys_readValid = tag_sys_rd && !AXI_areset;
    assign dma_rvalid    = tag_dma_rd && !AXI_areset;
    assign sys_readData  = sys_readValid ? rf_rdata : '0;
    assign dma_rdata     = dma_rvalid    ? rf_rdata : '0;

endmodule

// File: doc/regfile_access_arbiter.md
Name: regfile_access_arbiter

Overview:
- Single-cycle-access arbiter and sequencer for the shared DMA register file ("shared space").
- Requesters: AXI slave write FSM, AXI slave read FSM, DMA channel engine (descriptor fetch / status writeback).
- Grants exclusive ownership per burst:
  - AXI sides are locked for their whole `occupied` window.
  - DMA is time-sliced by a beat quota.
- Drives the single-port regfile and routes 1-cycle-latency read data back to the issuing requester.

Parameters:
- REGFILE_ADDRWIDTH, 9, regfile address width.
- REGFILE_DATAWIDTH, 9, regfile data width.
- DMA_MAX_BEATS, 4, max DMA accesses per grant when another requester is pending (>=1).
- BEAT_CNT_W, $clog2(DMA_MAX_BEATS+1), beat counter width.

Ports:
- AXI_aclk  in  1  clock
- AXI_areset  in  1  synchronous, active-high reset
- wr_occupied  in  1  slave write FSM burst-in-progress / request
- sys_writeEnable  in  1  slave write strobe
- sys_writeAddress  in  REGFILE_ADDRWIDTH  slave write address
- sys_writeData  in  REGFILE_DATAWIDTH  slave write data
- sys_writeReady  out  1  write side owns regfile
- rd_occupied  in  1  slave read FSM request
- sys_readEnable  in  1  slave read strobe
- sys_readAddress  in  REGFILE_ADDRWIDTH  slave read address
- sys_readReady  out  1  read side owns regfile
- sys_readData  out  REGFILE_DATAWIDTH  read return data
- sys_readValid  out  1  sys_readData valid
- dma_req  in  1  DMA engine request
- dma_en  in  1  DMA access strobe
- dma_we  in  1  1=write, 0=read
- dma_addr  in  REGFILE_ADDRWIDTH  DMA address
- dma_wdata  in  REGFILE_DATAWIDTH  DMA write data
- dma_ready  out  1  DMA owns regfile
- dma_rdata  out  REGFILE_DATAWIDTH  DMA read data
- dma_rvalid  out  1  dma_rdata valid
- rf_en  out  1  regfile access
- rf_we  out  1  regfile write
- rf_addr  out  REGFILE_ADDRWIDTH  regfile address
- rf_wdata  out  REGFILE_DATAWIDTH  regfile write data
- rf_rdata  in  REGFILE_DATAWIDTH  regfile read data, valid the cycle after rf_en & ~rf_we

Behaviour:

Reset (sync, AXI_areset=1):
- State = NONE; rr pointer = WR highest priority; beat counter = 0; read tag = none.
- All ready, rvalid, rf_en, rf_we = 0; data outputs = 0.

State machine (registered grant): NONE, GNT_WR, GNT_RD, GNT_DMA.
- Readies decode the state directly: sys_writeReady = (state==GNT_WR); likewise for read and DMA. No combinational path from requests to readies.
- Arbitration latency: a request seen in NONE gets its ready the next cycle.

Selection:
- Round-robin among active requests (wr_occupied, rd_occupied, dma_req).
- Priority order starts after the last granted owner.
- Pointer updates only when a grant is issued.

Release rules:
- GNT_WR: held while wr_occupied=1.
- GNT_RD: held while rd_occupied=1.
- GNT_DMA: held while dma_req=1, with a beat quota:
  - Counter increments on dma_en & dma_ready.
  - Reaching DMA_MAX_BEATS with another request pending → release.
  - Reaching DMA_MAX_BEATS with nothing else pending → counter clears, grant kept.
- On release, handover is direct to the next round-robin winner (excluding the releasing owner) with no NONE bubble; if none pending, go to NONE.

Access mux:
- rf_en = owner's strobe & owner's ready.
- rf_we: 1 for WR, 0 for RD, dma_we for DMA.
- rf_addr / rf_wdata taken from the owner; 0 when NONE.
- Strobes from non-owners are ignored (no buffering); requesters must wait for ready.

Read return:
- A 1-bit-per-source tag register captures the issuer on each read.
- Next cycle, rf_rdata is routed to sys_readData/sys_readValid or dma_rdata/dma_rvalid (one-cycle pulse).
- The tag is independent of grant state, so a read issued in a grant's last cycle returns correctly after handover.
- Back-to-back reads give one rvalid per cycle.

Boundary conditions:
- Simultaneous requests from NONE with pointer at reset: WR wins, then RD, then DMA.
- A requester dropping its request in the same cycle it is granted: the grant still lasts 1 cycle, then releases.
- Reset asserted mid-burst: grant dropped that edge; any pending rvalid suppressed.

Test Plan:
- Reset, then wr_occupied=1 for 5 cycles with sys_writeEnable on cycles 2-5 → sys_writeReady=1 from cycle 1; 4 rf_en/rf_we pulses with matching addr/data; state NONE after wr_occupied falls.
- wr_occupied, rd_occupied, dma_req all rise together → grant order WR, RD, DMA; each handover has zero bubble cycles.
- DMA_MAX_BEATS=4, dma_req+dma_en continuous, rd_occupied rises at beat 2 → DMA released after beat 4; sys_readReady=1 the next cycle; DMA re-granted after rd_occupied falls.
- DMA alone, 10 continuous beats → grant never drops; counter wraps every 4 beats.
- DMA read at addr 0x05 in its final granted cycle, RD granted next → dma_rvalid=1 with rf_rdata one cycle later; sys_readValid stays 0.
- AXI_areset pulsed during GNT_WR with a read outstanding → all readies 0 next cycle; no rvalid; WR wins the next simultaneous request.
